uart_rx_ctrl: RTL and testbench

Receive-side controller for the MiniUart receiving unit. It generates the 8x-baud sample enable that drives the receiver's `en_rx`. It detects the receiver's byte-available status, captures each byte into a small FIFO and clears the status with an `over_read` pulse. A simple pop interface is presented to the CPU bus glue, with a sticky overrun flag.

---
 rtl/uart_rx_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_ctrl
//  Purpose  : Receive-side controller for the MiniUart receiving unit.
//             Generates the 8x-baud sample enable, captures each received
//             byte into a small show-ahead FIFO, clears the receiver status
//             with a one-cycle over_read pulse and keeps a sticky overrun
//             flag for bytes lost on a full FIFO.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_ctrl #(
    parameter int DIV_W  = 16,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,        // asynchronous, active low
    input  logic [DIV_W-1:0]  divisor,
    input  logic              rx_en,
    output logic              en_rx,
    input  logic              rx_rs,
    input  logic [7:0]        rx_data,
    output logic              over_read,
    input  logic              rd_req,
    output logic [7:0]        rd_data,
    output logic              rd_empty,
    output logic [ADDR_W:0]   rd_count,
    output logic              overrun,
    input  logic              ovr_clr
);

    localparam int              c_DEPTH_N = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] c_DEPTH   = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_CAPTURE  = 2'd1,
        S_CLEAR    = 2'd2,
        S_WAIT_LOW = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Tick divider
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] r_div_cnt;
    logic             r_en_rx;
    logic [DIV_W-1:0] w_reload;

    // Divisors 0 and 1 both collapse to a reload of 0: a tick every cycle.
    assign w_reload = (divisor <= DIV_W'(1)) ? '0 : (divisor - DIV_W'(1));

    // Down counter; a tick is registered on the cycle the count hits zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div_cnt <= '0;
            r_en_rx   <= 1'b0;
        end else if (!rx_en) begin
            r_div_cnt <= w_reload;
            r_en_rx   <= 1'b0;
        end else if (r_div_cnt == '0) begin
            r_div_cnt <= w_reload;
            r_en_rx   <= 1'b1;
        end else begin
            r_div_cnt <= r_div_cnt - DIV_W'(1);
            r_en_rx   <= 1'b0;
        end
    end

    assign en_rx = r_en_rx;

    // ------------------------------------------------------------------
    // Receiver status synchronizer
    // ------------------------------------------------------------------
    logic r_rs_meta;
    logic r_rs_s;

    // Two-flop synchronizer; only r_rs_s is used downstream.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rs_meta <= 1'b0;
            r_rs_s    <= 1'b0;
        end else begin
            r_rs_meta <= rx_rs;
            r_rs_s    <= r_rs_meta;
        end
    end

    // ------------------------------------------------------------------
    // Capture FSM
    // ------------------------------------------------------------------
    state_t            r_state;
    state_t            w_next;
    logic              w_push;
    logic              w_drop;
    logic              w_over_read;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [ADDR_W:0]   r_count;

    assign w_full  = (r_count == c_DEPTH);
    assign w_empty = (r_count == '0);
    assign w_pop   = rd_req && !w_empty;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and capture decisions; a pop in the capture cycle frees
    // the slot the push needs, so a full FIFO still accepts the byte.
    always_comb begin
        w_next      = r_state;
        w_push      = 1'b0;
        w_drop      = 1'b0;
        w_over_read = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_rs_s) begin
                    w_next = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (!w_full || w_pop) begin
                    w_push = 1'b1;
                end else begin
                    w_drop = 1'b1;
                end
                w_next = S_CLEAR;
            end
            S_CLEAR: begin
                w_over_read = 1'b1;
                w_next      = S_WAIT_LOW;
            end
            S_WAIT_LOW: begin
                if (!r_rs_s) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign over_read = w_over_read;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [7:0]        r_mem [0:c_DEPTH_N-1];
    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W-1:0] r_rptr;

    // Pointers and occupancy; push and pop together leave the count alone.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + ADDR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + ADDR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (ADDR_W+1)'(1);
                2'b01:   r_count <= r_count - (ADDR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage; cleared on reset so the head byte reads 0 afterwards.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < c_DEPTH_N; i++) begin
                r_mem[i] <= 8'h00;
            end
        end else if (w_push) begin
            r_mem[r_wptr] <= rx_data;
        end
    end

    assign rd_data  = r_mem[r_rptr];
    assign rd_empty = w_empty;
    assign rd_count = r_count;

    // ------------------------------------------------------------------
    // Sticky overrun
    // ------------------------------------------------------------------
    logic r_overrun;

    // A drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (ovr_clr) begin
            r_overrun <= 1'b0;
        end
    end

    assign overrun = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_ctrl
//  Purpose  : Self-checking bench for uart_rx_ctrl with a queue-based
//             reference model and a scoreboard for popped bytes.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_ctrl;

    localparam int DIV_W  = 16;
    localparam int ADDR_W = 2;
    localparam int DEPTH  = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [DIV_W-1:0] divisor;
    logic             rx_en;
    logic             en_rx;
    logic             rx_rs;
    logic [7:0]       rx_data;
    logic             over_read;
    logic             rd_req;
    logic [7:0]       rd_data;
    logic             rd_empty;
    logic [ADDR_W:0]  rd_count;
    logic             overrun;
    logic             ovr_clr;

    uart_rx_ctrl #(.DIV_W(DIV_W), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .divisor   (divisor),
        .rx_en     (rx_en),
        .en_rx     (en_rx),
        .rx_rs     (rx_rs),
        .rx_data   (rx_data),
        .over_read (over_read),
        .rd_req    (rd_req),
        .rd_data   (rd_data),
        .rd_empty  (rd_empty),
        .rd_count  (rd_count),
        .overrun   (overrun),
        .ovr_clr   (ovr_clr)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: FIFO contents, sticky flag, bytes still to send.
    logic [7:0] mq[$];
    logic [7:0] sb[$];
    logic [7:0] tx_q[$];
    bit         model_ovr = 1'b0;
    int         snd_t = 100;   // cycles since current byte's status rose

    bit pop_rand = 0, pop_at_cap = 0, force_pop = 0;
    bit clr_now = 0, clr_at_cap = 0, clr_rand = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Scoreboard monitor: every DUT pop must match the next expected byte.
    always @(negedge clk) begin
        if (rst && rd_req && !rd_empty) begin
            n_total++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL pop_unexpected: got 0x%0h expected no pop", rd_data);
            end else begin
                logic [7:0] e;
                e = sb.pop_front();
                if (rd_data !== e) begin
                    n_bad++;
                    $display("FAIL pop_data: got 0x%0h expected 0x%0h", rd_data, e);
                end
            end
        end
    end

    // One clock cycle: check post-edge state, drive inputs, advance model.
    task automatic step();
        bit drop;
        chk("rd_count", int'(rd_count), mq.size());
        chk("rd_empty", int'(rd_empty), int'(mq.size() == 0));
        chk("overrun", int'(overrun), int'(model_ovr));
        chk("over_read", int'(over_read), int'(snd_t == 4));
        if (mq.size() > 0) chk("rd_head", int'(rd_data), int'(mq[0]));

        if (snd_t >= 7 && tx_q.size() > 0) begin
            rx_data = tx_q.pop_front();
            snd_t   = 0;
        end
        rx_rs   = (snd_t <= 3);
        rd_req  = force_pop | (pop_at_cap && snd_t == 3) | (pop_rand && $urandom_range(0, 2) == 0);
        ovr_clr = clr_now | (clr_at_cap && snd_t == 3) | (clr_rand && $urandom_range(0, 9) == 0);

        drop = 1'b0;
        if (rd_req && mq.size() > 0) sb.push_back(mq.pop_front());
        if (snd_t == 3) begin
            if (mq.size() < DEPTH) mq.push_back(rx_data);
            else drop = 1'b1;
        end
        if (drop) model_ovr = 1'b1;
        else if (ovr_clr) model_ovr = 1'b0;
        if (snd_t < 100) snd_t++;

        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pops(input int n);
        force_pop = 1;
        run(n);
        force_pop = 0;
    endtask

    initial begin
        int per, since, guard;
        bit exp_tick;

        rst = 1'b0; divisor = 16'd4; rx_en = 1'b0; rx_rs = 1'b0;
        rx_data = 8'h00; rd_req = 1'b0; ovr_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_en_rx", int'(en_rx), 0);
        chk("rst_over_read", int'(over_read), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_empty", int'(rd_empty), 1);
        chk("rst_count", int'(rd_count), 0);
        chk("rst_data", int'(rd_data), 0);
        rst = 1'b1;

        // ---------------- Tick divider ----------------
        repeat (2) @(posedge clk);
        #1;
        per = 4; since = 0;
        for (int k = 0; k < 70; k++) begin
            if (k == 0)  rx_en = 1'b1;
            if (k == 10) divisor = 16'd2;
            if (k == 25) divisor = 16'd0;
            if (k == 35) rx_en = 1'b0;
            if (k == 38) divisor = 16'($urandom_range(0, 7));
            if (k == 40) rx_en = 1'b1;
            if (k == 55) divisor = 16'($urandom_range(1, 5));
            @(posedge clk);
            #1;
            if (rx_en) begin
                since++;
                exp_tick = (since == per);
                if (exp_tick) begin
                    since = 0;
                    per = (divisor <= 1) ? 1 : int'(divisor);
                end
            end else begin
                exp_tick = 1'b0;
                since = 0;
                per = (divisor <= 1) ? 1 : int'(divisor);
            end
            chk("en_rx", int'(en_rx), int'(exp_tick));
        end
        rx_en = 1'b0;

        // ---------------- Single byte ----------------
        tx_q.push_back(8'h55);
        run(10);
        pops(1);

        // ---------------- Overflow ----------------
        tx_q.push_back(8'h01); tx_q.push_back(8'h02); tx_q.push_back(8'h03);
        tx_q.push_back(8'h04); tx_q.push_back(8'hAA);
        run(40);
        pops(5);
        clr_now = 1; run(1); clr_now = 0;

        // ---------------- Full + pop at capture ----------------
        for (int i = 0; i < 4; i++) tx_q.push_back(8'($urandom));
        run(32);
        tx_q.push_back(8'h77);
        pop_at_cap = 1; run(10); pop_at_cap = 0;
        pops(4);

        // ---------------- Pop while empty ----------------
        pops(2);
        tx_q.push_back(8'h3C);
        run(10);
        pops(1);

        // ---------------- Clear vs set ----------------
        for (int i = 0; i < 5; i++) tx_q.push_back(8'($urandom));
        clr_at_cap = 0;
        run(32);
        clr_at_cap = 1; run(8); clr_at_cap = 0;
        run(2);
        clr_now = 1; run(1); clr_now = 0;
        pops(4);

        // ---------------- Random traffic ----------------
        pop_rand = 1; clr_rand = 1;
        for (int i = 0; i < 14; i++) tx_q.push_back(8'($urandom));
        run(150);
        pop_rand = 0; clr_rand = 0;
        run(2);
        pops(5);

        // ---------------- Reset during CLEAR ----------------
        tx_q.push_back(8'h99);
        guard = 0;
        while (snd_t != 4 && guard < 50) begin
            step();
            guard++;
        end
        chk("clear_reached", int'(snd_t == 4), 1);
        chk("over_read_before_rst", int'(over_read), 1);
        rst = 1'b0;
        #1;
        chk("rst_mid_over_read", int'(over_read), 0);
        chk("rst_mid_empty", int'(rd_empty), 1);
        chk("rst_mid_count", int'(rd_count), 0);
        chk("rst_mid_overrun", int'(overrun), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        mq.delete(); sb.delete(); model_ovr = 1'b0;
        snd_t = 0;      // status still high: recaptured as a new byte
        run(10);
        pops(1);
        run(2);

        chk("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
